// File: rtl/uart_link_supervisor.sv
// uart_link_supervisor: sends one command byte to each selected submodule link
// in turn and checks the echo. A channel is retried on a wrong echo, a parity
// error or a lost echo, and each channel is reported as passed or failed.
//
// Handshake: a command transfers on a rising clk edge where cmd_valid and
// cmd_ready are both high. cmd_ready is high only in IDLE, so cmd_valid is a
// don't-care at all other times (including the cycle done is high).
module uart_link_supervisor #(
    parameter int N_CH           = 3,
    parameter int STARTUP_CYCLES = 24000000,
    parameter int TIMEOUT_CYCLES = 4800000,
    parameter int MAX_RETRY      = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [7:0]        cmd_byte,
    input  logic [N_CH-1:0]   cmd_mask,
    output logic [7:0]        tx_data,
    output logic [N_CH-1:0]   start_tx,
    input  logic [N_CH-1:0]   tx_busy,
    input  logic [8*N_CH-1:0] rx_data,
    input  logic [N_CH-1:0]   rx_done,
    input  logic [N_CH-1:0]   parity_error,
    output logic [N_CH-1:0]   ch_ok,
    output logic [N_CH-1:0]   ch_fail,
    output logic              done,
    output logic              busy,
    output logic [2:0]        dbg_state
);

    // Zero-valued parameters still get a one-bit counter.
    localparam int SU_W = (STARTUP_CYCLES > 0) ? $clog2(STARTUP_CYCLES + 1) : 1;
    localparam int TO_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam int AT_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    // Index can reach N_CH so the "past the last channel" case never wraps.
    localparam int IX_W = $clog2(N_CH + 1);

    // Terminal counts: the count is checked before increment, so the last
    // value seen is (limit - 1) and the state is left on that cycle.
    localparam logic [SU_W-1:0] SU_LAST = SU_W'((STARTUP_CYCLES > 0) ? STARTUP_CYCLES - 1 : 0);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam logic [AT_W-1:0] AT_MAX  = AT_W'(MAX_RETRY);

    typedef enum logic [2:0] {
        ST_STARTUP   = 3'd0,
        ST_IDLE      = 3'd1,
        ST_SELECT    = 3'd2,
        ST_SEND      = 3'd3,
        ST_WAIT_BUSY = 3'd4,
        ST_WAIT_ECHO = 3'd5,
        ST_FINISH    = 3'd6
    } state_t;

    state_t            state_q, state_d;
    logic [SU_W-1:0]   su_q, su_d;
    logic [TO_W-1:0]   tmo_q, tmo_d;
    logic [AT_W-1:0]   att_q, att_d;
    logic [IX_W-1:0]   idx_q, idx_d;
    logic [N_CH-1:0]   mask_q, mask_d;
    logic [7:0]        tx_data_q, tx_data_d;
    logic [N_CH-1:0]   ok_q, ok_d;
    logic [N_CH-1:0]   fail_q, fail_d;
    logic              seen_q, seen_d;

    logic              sel_busy, sel_done, sel_perr;
    logic [7:0]        sel_rx;
    logic [N_CH-1:0]   cur_onehot;
    logic [N_CH-1:0]   rem;
    logic              attempt_fail;

    // Pick out the current channel's link signals.
    always_comb begin
        sel_busy   = 1'b0;
        sel_done   = 1'b0;
        sel_perr   = 1'b0;
        sel_rx     = 8'h00;
        cur_onehot = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (idx_q == IX_W'(i)) begin
                sel_busy      = tx_busy[i];
                sel_done      = rx_done[i];
                sel_perr      = parity_error[i];
                sel_rx        = rx_data[8*i +: 8];
                cur_onehot[i] = 1'b1;
            end
        end
    end

    // Mask bits from the current index upward; bit 0 is the current channel.
    assign rem = mask_q >> idx_q;

    // State and datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_STARTUP;
            su_q      <= '0;
            tmo_q     <= '0;
            att_q     <= '0;
            idx_q     <= '0;
            mask_q    <= '0;
            tx_data_q <= 8'h00;
            ok_q      <= '0;
            fail_q    <= '0;
            seen_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            su_q      <= su_d;
            tmo_q     <= tmo_d;
            att_q     <= att_d;
            idx_q     <= idx_d;
            mask_q    <= mask_d;
            tx_data_q <= tx_data_d;
            ok_q      <= ok_d;
            fail_q    <= fail_d;
            seen_q    <= seen_d;
        end
    end

    // Next-state and counter/status updates.
    always_comb begin
        state_d      = state_q;
        su_d         = su_q;
        tmo_d        = tmo_q;
        att_d        = att_q;
        idx_d        = idx_q;
        mask_d       = mask_q;
        tx_data_d    = tx_data_q;
        ok_d         = ok_q;
        fail_d       = fail_q;
        seen_d       = seen_q;
        attempt_fail = 1'b0;

        case (state_q)
            ST_STARTUP: begin
                if (su_q >= SU_LAST) state_d = ST_IDLE;
                else                 su_d    = su_q + SU_W'(1);
            end
            ST_IDLE: begin
                if (cmd_valid) begin
                    tx_data_d = cmd_byte;
                    mask_d    = cmd_mask;
                    ok_d      = '0;
                    fail_d    = '0;
                    idx_d     = '0;
                    state_d   = ST_SELECT;
                end
            end
            ST_SELECT: begin
                // No selected channel left: done (also covers an empty mask).
                if (rem == '0) begin
                    state_d = ST_FINISH;
                end else if (!rem[0]) begin
                    idx_d = idx_q + IX_W'(1);
                end else begin
                    att_d   = '0;
                    state_d = ST_SEND;
                end
            end
            ST_SEND: begin
                tmo_d   = '0;
                seen_d  = 1'b0;
                state_d = ST_WAIT_BUSY;
            end
            ST_WAIT_BUSY: begin
                if (!seen_q) begin
                    // Transmitter must acknowledge with busy within the timeout.
                    if (sel_busy) begin
                        seen_d = 1'b1;
                        tmo_d  = '0;
                    end else if (tmo_q >= TO_LAST) begin
                        attempt_fail = 1'b1;
                    end else begin
                        tmo_d = tmo_q + TO_W'(1);
                    end
                end else if (!sel_busy) begin
                    // Echo timeout starts on the falling edge of busy.
                    tmo_d   = '0;
                    state_d = ST_WAIT_ECHO;
                end
            end
            ST_WAIT_ECHO: begin
                // rx_done is tested first so it wins over a same-cycle timeout.
                if (sel_done) begin
                    if ((sel_rx == tx_data_q) && !sel_perr) begin
                        ok_d    = ok_q | cur_onehot;
                        idx_d   = idx_q + IX_W'(1);
                        state_d = ST_SELECT;
                    end else begin
                        attempt_fail = 1'b1;
                    end
                end else if (tmo_q >= TO_LAST) begin
                    attempt_fail = 1'b1;
                end else begin
                    tmo_d = tmo_q + TO_W'(1);
                end
            end
            ST_FINISH: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_STARTUP;
            end
        endcase

        if (attempt_fail) begin
            if (att_q < AT_MAX) begin
                att_d   = att_q + AT_W'(1);
                state_d = ST_SEND;
            end else begin
                fail_d  = fail_q | cur_onehot;
                idx_d   = idx_q + IX_W'(1);
                state_d = ST_SELECT;
            end
        end
    end

    // Outputs decoded from the current state and registers.
    always_comb begin
        cmd_ready = (state_q == ST_IDLE);
        done      = (state_q == ST_FINISH);
        busy      = (state_q == ST_SELECT) || (state_q == ST_SEND) ||
                    (state_q == ST_WAIT_BUSY) || (state_q == ST_WAIT_ECHO);
        start_tx  = (state_q == ST_SEND) ? cur_onehot : '0;
        tx_data   = tx_data_q;
        ch_ok     = ok_q;
        ch_fail   = fail_q;
        dbg_state = state_q;
    end

endmodule
